// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parametrised width and depth.
// Provides a fill level, almost-full/almost-empty flags, sticky over/underflow flags and a synchronous flush.
module sync_fifo_param #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int AFULL_TH   = 12,
   parameter int AEMPTY_TH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_W-1:0]     din,
   input  logic                  din_dv,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     dout,
   output logic                  dout_dv,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  aempty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   localparam logic [PW-1:0] DEPTH_LV  = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
   localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [PW-1:0]     level_reg;
   logic [PW-1:0]     level_next;
   logic [DATA_W-1:0] dout_reg;
   logic              dout_dv_reg;
   logic              overflow_reg;
   logic              underflow_reg;

   logic              wa;
   logic              ra;

   assign full   = (level_reg == DEPTH_LV);
   assign empty  = (level_reg == '0);
   assign afull  = (level_reg >= AFULL_LV);
   assign aempty = (level_reg <= AEMPTY_LV);

   // A write into a full FIFO is still taken when a read frees a slot in the same cycle.
   assign ra = rd_en & ~empty & ~clr;
   assign wa = din_dv & (~full | ra) & ~clr;

   always_comb begin
      level_next = level_reg;
      if (wa && !ra) begin
         level_next = level_reg + PW'(1);
      end else if (ra && !wa) begin
         level_next = level_reg - PW'(1);
      end
   end

   // Storage is left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wa) begin
         mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (clr) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         level_reg <= level_next;
         if (wa) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (ra) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (din_dv && !wa) begin
            overflow_reg <= 1'b1;
         end
         if (rd_en && !ra) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   // DOUT keeps its last value on idle cycles and through a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_reg    <= '0;
         dout_dv_reg <= 1'b0;
      end else if (ra) begin
         dout_reg    <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
         dout_dv_reg <= 1'b1;
      end else begin
         dout_dv_reg <= 1'b0;
      end
   end

   assign dout      = dout_reg;
   assign dout_dv   = dout_dv_reg;
   assign level     = level_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param, checked against a queue-based reference model.
module tb_sync_fifo_param;

   localparam int DATA_W     = 8;
   localparam int DEPTH_LOG2 = 2;
   localparam int DEPTH      = 4;
   localparam int AFULL_TH   = 3;
   localparam int AEMPTY_TH  = 1;

   logic                clk;
   logic                rst_n;
   logic                clr;
   logic [DATA_W-1:0]   din;
   logic                din_dv;
   logic                rd_en;
   logic [DATA_W-1:0]   dout;
   logic                dout_dv;
   logic                full;
   logic                empty;
   logic                afull;
   logic                aempty;
   logic [DEPTH_LOG2:0] level;
   logic                overflow;
   logic                underflow;

   sync_fifo_param #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .AFULL_TH   (AFULL_TH),
      .AEMPTY_TH  (AEMPTY_TH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .din       (din),
      .din_dv    (din_dv),
      .rd_en     (rd_en),
      .dout      (dout),
      .dout_dv   (dout_dv),
      .full      (full),
      .empty     (empty),
      .afull     (afull),
      .aempty    (aempty),
      .level     (level),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int check_count = 0;
   int error_count = 0;
   int txn_count   = 0;

   logic [DATA_W-1:0] model_q [$];
   logic [DATA_W-1:0] model_dout = '0;
   logic              model_dv   = 1'b0;
   logic              model_ovf  = 1'b0;
   logic              model_udf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         error_count++;
         $display("FAIL %s observed %0h expected %0h (txn %0d)", tag, obs, exp, txn_count);
      end
   endtask

   task automatic compare_all();
      int lv;
      lv = model_q.size();
      check("level",     32'(level),     32'(lv));
      check("full",      32'(full),      32'(lv == DEPTH));
      check("empty",     32'(empty),     32'(lv == 0));
      check("afull",     32'(afull),     32'(lv >= AFULL_TH));
      check("aempty",    32'(aempty),    32'(lv <= AEMPTY_TH));
      check("dout",      32'(dout),      32'(model_dout));
      check("dout_dv",   32'(dout_dv),   32'(model_dv));
      check("overflow",  32'(overflow),  32'(model_ovf));
      check("underflow", 32'(underflow), 32'(model_udf));
   endtask

   task automatic model_reset();
      model_q.delete();
      model_dout = '0;
      model_dv   = 1'b0;
      model_ovf  = 1'b0;
      model_udf  = 1'b0;
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge, check just after it.
   task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
      bit can_rd;
      bit can_wr;
      @(negedge clk);
      din_dv = w;
      din    = d;
      rd_en  = r;
      clr    = c;
      @(posedge clk);
      if (c) begin
         model_q.delete();
         model_dv  = 1'b0;
         model_ovf = 1'b0;
         model_udf = 1'b0;
      end else begin
         can_rd = r && (model_q.size() > 0);
         can_wr = w && ((model_q.size() < DEPTH) || can_rd);
         if (can_rd) begin
            model_dout = model_q.pop_front();
            model_dv   = 1'b1;
         end else begin
            model_dv = 1'b0;
         end
         if (can_wr) model_q.push_back(d);
         if (w && !can_wr) model_ovf = 1'b1;
         if (r && !can_rd) model_udf = 1'b1;
      end
      #1;
      txn_count++;
      $display("txn %0d wr=%0d din=%02h rd=%0d clr=%0d -> level=%0d dout=%02h dv=%0d ovf=%0d udf=%0d",
               txn_count, w, d, r, c, level, dout, dout_dv, overflow, underflow);
      compare_all();
   endtask

   initial begin
      rst_n  = 1'b0;
      clr    = 1'b0;
      din    = '0;
      din_dv = 1'b0;
      rd_en  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // 1: fill
      cycle(1, 8'h11, 0, 0);
      cycle(1, 8'h22, 0, 0);
      cycle(1, 8'h33, 0, 0);
      cycle(1, 8'h44, 0, 0);
      // 2: overflow from full, then drain in order
      cycle(1, 8'h55, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 0, 0);
      // 3: simultaneous read/write from empty
      cycle(1, 8'hA5, 1, 0);
      cycle(0, 8'h00, 1, 0);
      // 4: streaming at full across pointer wrap
      for (int i = 0; i < 4; i++) cycle(1, 8'(8'h61 + i), 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 8'(8'h66 + i), 1, 0);
      // 5: flush at level 3 with overflow set
      cycle(1, 8'hEE, 0, 0);
      cycle(0, 8'h00, 1, 0);
      cycle(1, 8'hCC, 1, 1);
      cycle(0, 8'h00, 0, 0);
      // 6: asynchronous reset between edges at level 2
      cycle(1, 8'h12, 0, 0);
      cycle(1, 8'h34, 0, 0);
      @(negedge clk);
      din_dv = 1'b0;
      rd_en  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 250; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
